// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg -- shared types and constants for the ALU sequencing controller.
//   state_t         : FSM state codes (also driven out on the stage port)
//   HOLDOFF_DEFAULT : default holdoff length in cycles after any strobe
package alu_seq_pkg;

  localparam int unsigned HOLDOFF_DEFAULT = 4;

  typedef enum logic [2:0] {
    WAIT_A   = 3'd0,
    WAIT_B   = 3'd1,
    WAIT_OP  = 3'd2,
    EXEC     = 3'd3,
    SHOW_RES = 3'd4
  } state_t;

endpackage

// File: rtl/alu_seq_ctrl_rise_edge.sv
// rise_edge -- registered rising-edge detector.
//   clk    : clock
//   reset  : synchronous active-high reset
//   i_d    : level input (already debounced)
//   o_rise : high for the cycle where i_d is high and its registered copy is low
module rise_edge (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_rise
);

  logic r_prev;

  // Reset loads the live input rather than 0, so a button already held
  // while reset is released does not count as a fresh press.
  always_ff @(posedge clk) begin
    if (reset) r_prev <= i_d;
    else       r_prev <= i_d;
  end

  assign o_rise = i_d & ~r_prev;

endmodule

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl -- steps an ALU datapath through A / B / opcode / execute /
// show-result using two debounced buttons.
//   clk, reset          : clock, synchronous active-high reset
//   enter, back         : level buttons; only rising edges are acted on
//   load_A/load_B/
//   load_Op/updateRes   : one-cycle, mutually exclusive load strobes
//   stage               : registered current state code
//   op_count            : completed operations, wraps at 256
module alu_seq_ctrl
  import alu_seq_pkg::*;
#(
  parameter int unsigned HOLDOFF = HOLDOFF_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enter,
  input  logic       back,
  output logic       load_A,
  output logic       load_B,
  output logic       load_Op,
  output logic       updateRes,
  output logic [2:0] stage,
  output logic [7:0] op_count
);

  localparam logic [3:0] HOLD_LOAD = 4'(HOLDOFF);

  logic       w_enter_rise;
  logic       w_back_rise;
  logic       w_accept;

  state_t     r_state;
  logic [3:0] r_hold;
  logic [7:0] r_op_count;
  logic       r_load_a;
  logic       r_load_b;
  logic       r_load_op;
  logic       r_update_res;

  rise_edge u_enter_edge (
    .clk    (clk),
    .reset  (reset),
    .i_d    (enter),
    .o_rise (w_enter_rise)
  );

  rise_edge u_back_edge (
    .clk    (clk),
    .reset  (reset),
    .i_d    (back),
    .o_rise (w_back_rise)
  );

  // Edges are dropped (not queued) while the holdoff counter runs.
  assign w_accept = (r_hold == 4'd0);

  // NOTE: all state and strobe registers use non-blocking assignments so every
  // read in this block sees the value from before the clock edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= WAIT_A;
      r_hold       <= 4'd0;
      r_op_count   <= 8'd0;
      r_load_a     <= 1'b0;
      r_load_b     <= 1'b0;
      r_load_op    <= 1'b0;
      r_update_res <= 1'b0;
    end else begin
      // Strobes default low so each lasts exactly one cycle.
      r_load_a     <= 1'b0;
      r_load_b     <= 1'b0;
      r_load_op    <= 1'b0;
      r_update_res <= 1'b0;

      if (r_hold != 4'd0) r_hold <= r_hold - 4'd1;

      if (r_state == EXEC) begin
        // EXEC ignores buttons and always finishes in one cycle.
        r_state      <= SHOW_RES;
        r_update_res <= 1'b1;
        r_op_count   <= r_op_count + 8'd1;
        r_hold       <= HOLD_LOAD;
      end else if (w_accept && w_back_rise) begin
        // Back wins over a simultaneous enter; it issues no strobe and
        // therefore does not start a holdoff.
        unique case (r_state)
          WAIT_B:   r_state <= WAIT_A;
          WAIT_OP:  r_state <= WAIT_B;
          SHOW_RES: r_state <= WAIT_OP;
          default:  r_state <= r_state;
        endcase
      end else if (w_accept && w_enter_rise) begin
        unique case (r_state)
          WAIT_A: begin
            r_state  <= WAIT_B;
            r_load_a <= 1'b1;
            r_hold   <= HOLD_LOAD;
          end
          WAIT_B: begin
            r_state  <= WAIT_OP;
            r_load_b <= 1'b1;
            r_hold   <= HOLD_LOAD;
          end
          WAIT_OP: begin
            r_state   <= EXEC;
            r_load_op <= 1'b1;
            r_hold    <= HOLD_LOAD;
          end
          SHOW_RES: r_state <= WAIT_A;
          default:  r_state <= r_state;
        endcase
      end
    end
  end

  assign load_A    = r_load_a;
  assign load_B    = r_load_b;
  assign load_Op   = r_load_op;
  assign updateRes = r_update_res;
  assign stage     = r_state;
  assign op_count  = r_op_count;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl -- self-checking bench for alu_seq_ctrl (HOLDOFF = 4).
// A behavioural model advances on each rising edge; a compare process checks
// every DUT output against it on each falling edge. Directed sequences add
// hand-computed literal expectations.
module tb_alu_seq_ctrl;

  localparam int HOLDOFF = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enter = 1'b0;
  logic       back = 1'b0;
  logic       load_A, load_B, load_Op, updateRes;
  logic [2:0] stage;
  logic [7:0] op_count;
  logic [3:0] dut_strobes;

  int tests_run = 0;
  int tests_failed = 0;
  int n_a = 0, n_b = 0, n_op = 0, n_res = 0;

  alu_seq_ctrl #(.HOLDOFF(HOLDOFF)) dut (
    .clk       (clk),
    .reset     (reset),
    .enter     (enter),
    .back      (back),
    .load_A    (load_A),
    .load_B    (load_B),
    .load_Op   (load_Op),
    .updateRes (updateRes),
    .stage     (stage),
    .op_count  (op_count)
  );

  always #5 clk = ~clk;

  assign dut_strobes = {updateRes, load_Op, load_B, load_A};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Stages are plain integers 0..4; a strobe is bit <stage> of a 4-bit
  // vector (A,B,Op,Res), emitted when leaving that stage forwards.
  int         m_stage = 0;
  int         m_hold = 0;
  int         m_cnt = 0;
  logic [3:0] m_strobe = 4'b0;
  logic       m_pe = 1'b0;
  logic       m_pb = 1'b0;
  bit         m_valid = 1'b0;

  always @(posedge clk) begin
    int         s, h, c;
    logic [3:0] st;
    bit         e, b;
    s  = m_stage;
    h  = m_hold;
    c  = m_cnt;
    st = 4'b0;
    e  = enter && !m_pe;
    b  = back && !m_pb;
    if (reset) begin
      s = 0;
      h = 0;
      c = 0;
    end else if (s == 3) begin
      s  = 4;
      st = 4'b1000;
      c  = (c + 1) % 256;
      h  = HOLDOFF;
    end else if (h > 0) begin
      h = h - 1;
    end else if (b) begin
      if (s == 4)      s = 2;
      else if (s != 0) s = s - 1;
    end else if (e) begin
      if (s == 4) s = 0;
      else begin
        st = 4'(1 << s);
        s  = s + 1;
        h  = HOLDOFF;
      end
    end
    m_stage  <= s;
    m_hold   <= h;
    m_cnt    <= c;
    m_strobe <= st;
    m_pe     <= enter;
    m_pb     <= back;
    if (reset) m_valid <= 1'b1;
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (m_valid) begin
      check("stage", 32'(stage), m_stage);
      check("strobes", 32'(dut_strobes), 32'(m_strobe));
      check("op_count", 32'(op_count), m_cnt);
      check("one_strobe_max", 32'($countones(dut_strobes) <= 1), 1);
      n_a   += int'(load_A);
      n_b   += int'(load_B);
      n_op  += int'(load_Op);
      n_res += int'(updateRes);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Each press returns on the falling edge after its rising edge was sampled.
  task automatic press_enter();
    enter = 1'b1;
    @(negedge clk);
    enter = 1'b0;
  endtask

  task automatic press_back();
    back = 1'b1;
    @(negedge clk);
    back = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    wait_cyc(3);
    reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0;

    // Reset for 3 cycles, then check reset state.
    wait_cyc(3);
    reset = 1'b0;
    check("rst_stage", 32'(stage), 0);
    check("rst_strobes", 32'(dut_strobes), 0);
    check("rst_op_count", 32'(op_count), 0);

    // Full sequence, enter pulses 8 cycles apart.
    press_enter();
    check("seq_stage1", 32'(stage), 1);
    check("seq_load_A", 32'(load_A), 1);
    wait_cyc(7);
    press_enter();
    check("seq_stage2", 32'(stage), 2);
    check("seq_load_B", 32'(load_B), 1);
    wait_cyc(7);
    press_enter();
    check("seq_stage3", 32'(stage), 3);
    check("seq_load_Op", 32'(load_Op), 1);
    wait_cyc(1);
    check("seq_stage4", 32'(stage), 4);
    check("seq_updateRes_next", 32'(updateRes), 1);
    check("seq_load_Op_gone", 32'(load_Op), 0);
    wait_cyc(6);
    press_enter();
    check("seq_stage0", 32'(stage), 0);
    check("seq_no_strobe", 32'(dut_strobes), 0);
    check("seq_op_count", 32'(op_count), 1);
    wait_cyc(7);

    // Enter held for 20 cycles counts once.
    do_reset();
    a0 = n_a;
    enter = 1'b1;
    wait_cyc(20);
    check("held_one_load_A", n_a - a0, 1);
    check("held_stage", 32'(stage), 1);
    enter = 1'b0;
    wait_cyc(2);

    // Holdoff: edge 2 cycles after load_A dropped, edge 6 cycles after accepted.
    do_reset();
    press_enter();
    check("ho_load_A", 32'(load_A), 1);
    wait_cyc(1);
    press_enter();
    check("ho_discard_stage", 32'(stage), 1);
    check("ho_discard_load_B", 32'(load_B), 0);
    wait_cyc(3);
    press_enter();
    check("ho_accept_load_B", 32'(load_B), 1);
    check("ho_accept_stage", 32'(stage), 2);

    // Enter and back together in WAIT_OP: back wins, no strobe.
    wait_cyc(6);
    enter = 1'b1;
    back  = 1'b1;
    @(negedge clk);
    enter = 1'b0;
    back  = 1'b0;
    check("both_stage", 32'(stage), 1);
    check("both_no_strobe", 32'(dut_strobes), 0);
    // Back starts no holdoff, so an enter right after is taken.
    wait_cyc(1);
    press_enter();
    check("after_back_load_B", 32'(load_B), 1);
    check("after_back_stage", 32'(stage), 2);

    // Back navigation from SHOW_RES down to WAIT_A.
    wait_cyc(5);
    press_enter();
    check("nav_exec", 32'(stage), 3);
    wait_cyc(6);
    check("nav_show", 32'(stage), 4);
    press_back();
    check("nav_back_to_op", 32'(stage), 2);
    check("nav_back_no_strobe", 32'(dut_strobes), 0);
    wait_cyc(1);
    press_back();
    check("nav_back_to_b", 32'(stage), 1);
    wait_cyc(1);
    press_back();
    check("nav_back_to_a", 32'(stage), 0);
    wait_cyc(1);
    press_back();
    check("nav_back_stay_a", 32'(stage), 0);
    check("nav_op_count", 32'(op_count), 1);

    // Reset during EXEC cancels updateRes.
    do_reset();
    press_enter();
    wait_cyc(6);
    press_enter();
    wait_cyc(6);
    press_enter();
    check("rexec_in_exec", 32'(stage), 3);
    reset = 1'b1;
    @(negedge clk);
    check("rexec_no_updateRes", 32'(updateRes), 0);
    check("rexec_stage", 32'(stage), 0);
    check("rexec_op_count", 32'(op_count), 0);
    reset = 1'b0;
    wait_cyc(2);
    check("rexec_still_no_res", 32'(updateRes), 0);
    check("rexec_count_after", 32'(op_count), 0);

    // 256 complete sequences: op_count wraps to 0.
    do_reset();
    for (int s = 0; s < 256; s++) begin
      for (int p = 0; p < 4; p++) begin
        press_enter();
        wait_cyc(5);
      end
      if (s == 254) check("wrap_255", 32'(op_count), 255);
    end
    check("wrap_zero", 32'(op_count), 0);
    check("wrap_stage", 32'(stage), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/alu_seq_ctrl.md
ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

Interface
REQ-001 SHALL have parameter HOLDOFF, default 4: cycles after any strobe during which enter/back edges are discarded (range 0..15).
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port enter, input, 1 bit: debounced, level "advance" button.
REQ-005 SHALL have port back, input, 1 bit: debounced, level "step back" button.
REQ-006 SHALL have port load_A, output, 1 bit: one-cycle strobe to the ALU A register.
REQ-007 SHALL have port load_B, output, 1 bit: one-cycle strobe to the ALU B register.
REQ-008 SHALL have port load_Op, output, 1 bit: one-cycle strobe to the ALU opcode register.
REQ-009 SHALL have port updateRes, output, 1 bit: one-cycle strobe to the ALU result/flags register.
REQ-010 SHALL have port stage, output, 3 bits: current state code.
REQ-011 SHALL have port op_count, output, 8 bits: count of completed operations.

Function
REQ-012 SHALL rising-edge-detect enter and back against a registered copy; a level held high counts once.
REQ-013 SHALL implement states WAIT_A(0), WAIT_B(1), WAIT_OP(2), EXEC(3), SHOW_RES(4).
REQ-014 On an enter edge: WAIT_A->WAIT_B with load_A; WAIT_B->WAIT_OP with load_B; WAIT_OP->EXEC with load_Op; SHOW_RES->WAIT_A with no strobe.
REQ-015 EXEC SHALL last exactly one cycle, then go to SHOW_RES with updateRes, so updateRes follows load_Op by exactly 1 cycle.
REQ-016 On a back edge: WAIT_B->WAIT_A; WAIT_OP->WAIT_B; SHOW_RES->WAIT_OP; WAIT_A stays. No strobe is issued on back.
REQ-017 If enter and back edges occur in the same cycle, back SHALL win and enter SHALL be discarded.
REQ-018 Edges arriving in EXEC SHALL be discarded.
REQ-019 Strobes SHALL be registered: an edge sampled at rising clock n drives its strobe high for cycle n+1 only.
REQ-020 Strobes SHALL be mutually exclusive: at most one of the four is high in any cycle.
REQ-021 Every strobe SHALL load a holdoff counter with HOLDOFF. The counter decrements to 0. Edges seen while it is nonzero SHALL be discarded, not queued.
REQ-022 The edge-detect registers SHALL keep updating during holdoff, so a level still held when holdoff ends produces no edge.
REQ-023 op_count SHALL increment by 1 in the cycle updateRes is high and wrap from 255 to 0.
REQ-024 stage SHALL reflect the registered state code with no combinational path from the inputs.

Reset
REQ-025 While reset is high at a clock edge: state = WAIT_A, all strobes = 0, op_count = 0, holdoff counter = 0, and edge registers take the current input values.
REQ-026 Reset asserted mid-sequence, including in EXEC, SHALL cancel any pending updateRes; no strobe SHALL appear in the cycle after reset.
REQ-027 Reset SHALL dominate all edges in the same cycle.

Structure
REQ-028 Package alu_seq_pkg SHALL hold the state_t enum (codes per REQ-013) and the HOLDOFF_DEFAULT constant.
REQ-029 A single sub-module rise_edge (registered rising-edge detector, synchronous reset) SHALL be instantiated once for enter and once for back.
REQ-030 The FSM, holdoff counter and op_count SHALL live in alu_seq_ctrl.

Verification (HOLDOFF=4)
REQ-031 Reset 3 cycles, then enter pulses spaced 8 cycles apart, 4 times:
- expect load_A, load_B, load_Op, then updateRes exactly 1 cycle after load_Op;
- stage sequence 0,1,2,3,4,0;
- op_count = 1.
REQ-032 Enter held high for 20 cycles from WAIT_A -> exactly one load_A, stage = 1.
REQ-033 Second enter edge 2 cycles after load_A -> discarded, stage stays 1; same edge at 6 cycles -> load_B.
REQ-034 Enter and back edges in the same cycle while in WAIT_OP -> no strobe, stage = 1.
REQ-035 Reset asserted in the EXEC cycle -> no updateRes, stage = 0, op_count unchanged at 0 from reset.
REQ-036 Run 256 complete sequences -> op_count wraps to 0. Throughout, a bench checker confirms at most one strobe high per cycle.
